// File: rtl/bf_pkg.sv
// Shared definitions for the bound flasher: phase encoding, default geometry
// and the level register width helper.
package bf_pkg;

    typedef enum logic [2:0] {
        PH_IDLE = 3'd0,
        PH_UP1  = 3'd1,
        PH_DN1  = 3'd2,
        PH_UP2  = 3'd3,
        PH_DN2  = 3'd4,
        PH_UP3  = 3'd5,
        PH_DN3  = 3'd6
    } bf_phase_e;

    localparam int unsigned BF_N_LAMPS = 16;
    localparam int unsigned BF_B_LO    = 6;
    localparam int unsigned BF_B_HI    = 11;

    // Bits needed to hold a level in 0..n inclusive.
    function automatic int unsigned bf_lvl_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/bf_level_counter.sv
// Up/down counter holding the lamp level. Load has priority over counting.
module bf_level_counter #(
    parameter int unsigned W = 5
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         upcount,
    input  logic         enable,
    output logic [W-1:0] out
);

    // Level register: async clear, synchronous load or single step.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out <= '0;
        end else if (load) begin
            out <= load_val;
        end else if (enable) begin
            out <= upcount ? out + W'(1) : out - W'(1);
        end
    end

endmodule

// File: rtl/bound_flasher_ctrl.sv
// Bound flasher sequencing controller: six-phase up/down lamp pattern with
// flick-triggered kickback at the B_LO / B_HI boundaries in UP2 and UP3.
module bound_flasher_ctrl
    import bf_pkg::*;
#(
    parameter int unsigned N_LAMPS = BF_N_LAMPS,
    parameter int unsigned B_LO    = BF_B_LO,
    parameter int unsigned B_HI    = BF_B_HI
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               flick,
    input  logic               step_en,
    output logic [N_LAMPS-1:0] lamps,
    output logic               busy,
    output logic [2:0]         phase
);

    localparam int unsigned W = bf_lvl_width(N_LAMPS);

    localparam logic [W-1:0] LV_ZERO = '0;
    localparam logic [W-1:0] LV_ONE  = W'(1);
    localparam logic [W-1:0] LV_LO   = W'(B_LO);
    localparam logic [W-1:0] LV_LOM1 = W'(B_LO - 1);
    localparam logic [W-1:0] LV_HI   = W'(B_HI);
    localparam logic [W-1:0] LV_TOP  = W'(N_LAMPS);

    bf_phase_e    r_phase;
    bf_phase_e    w_phase_nxt;
    logic [W-1:0] w_lvl;
    logic [W-1:0] w_new;
    logic         w_up;
    logic         w_en;
    logic         w_load;
    logic         w_kick;

    bf_level_counter #(
        .W (W)
    ) u_level (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (w_load),
        .load_val (LV_ONE),
        .upcount  (w_up),
        .enable   (w_en),
        .out      (w_lvl)
    );

    // Phase register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_phase <= PH_IDLE;
        end else begin
            r_phase <= w_phase_nxt;
        end
    end

    // Next phase and counter commands; targets are compared against the
    // post-step level so the phase change lands with the step that hits it.
    always_comb begin
        w_phase_nxt = r_phase;
        w_load      = 1'b0;
        w_en        = 1'b0;
        w_up        = (r_phase == PH_UP1) || (r_phase == PH_UP2) ||
                      (r_phase == PH_UP3);
        w_new       = w_up ? w_lvl + LV_ONE : w_lvl - LV_ONE;
        w_kick      = flick && ((w_new == LV_LO) || (w_new == LV_HI));
        if (step_en) begin
            w_en = (r_phase != PH_IDLE);
            case (r_phase)
                PH_IDLE: begin
                    if (flick) begin
                        w_load      = 1'b1;
                        w_phase_nxt = PH_UP1;
                    end
                end
                PH_UP1: if (w_new == LV_LO)   w_phase_nxt = PH_DN1;
                PH_DN1: if (w_new == LV_ZERO) w_phase_nxt = PH_UP2;
                PH_UP2: begin
                    if (w_kick)               w_phase_nxt = PH_DN1;
                    else if (w_new == LV_HI)  w_phase_nxt = PH_DN2;
                end
                PH_DN2: if (w_new == LV_LOM1) w_phase_nxt = PH_UP3;
                PH_UP3: begin
                    if (w_kick)               w_phase_nxt = PH_DN2;
                    else if (w_new == LV_TOP) w_phase_nxt = PH_DN3;
                end
                PH_DN3: if (w_new == LV_ZERO) w_phase_nxt = PH_IDLE;
                default: begin
                    w_en        = 1'b0;
                    w_phase_nxt = PH_IDLE;
                end
            endcase
        end
    end

    // Thermometer decode of the registered level.
    always_comb begin
        lamps = '0;
        for (int unsigned i = 0; i < N_LAMPS; i++) begin
            lamps[i] = (i < 32'(w_lvl));
        end
    end

    assign busy  = (r_phase != PH_IDLE);
    assign phase = r_phase;

endmodule

// File: tb/tb_bound_flasher_ctrl.sv
// Scoreboard bench for bound_flasher_ctrl: each driven step pushes the
// expected level/phase; a negedge monitor pops and compares.
module tb_bound_flasher_ctrl;

    localparam int P_IDLE = 0;
    localparam int P_UP1  = 1;
    localparam int P_DN1  = 2;
    localparam int P_UP2  = 3;
    localparam int P_DN2  = 4;
    localparam int P_UP3  = 5;
    localparam int P_DN3  = 6;

    logic        clk;
    logic        reset_n;
    logic        flick;
    logic        step_en;
    logic [15:0] lamps;
    logic        busy;
    logic [2:0]  phase;

    typedef struct {
        int lvl;
        int ph;
        int idx;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_pushed = 0;

    bound_flasher_ctrl #(
        .N_LAMPS (16),
        .B_LO    (6),
        .B_HI    (11)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .flick   (flick),
        .step_en (step_en),
        .lamps   (lamps),
        .busy    (busy),
        .phase   (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int idx, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s #%0d: got 0x%0h expected 0x%0h", nm, idx, act, exp);
    endtask

    function automatic int therm(input int lvl);
        logic [31:0] t;
        t = (32'd1 << lvl) - 32'd1;
        return int'(t[15:0]);
    endfunction

    // Monitor: outputs for a step are compared on the negedge after it.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("lamps", e.idx, int'(lamps), therm(e.lvl));
            chk("phase", e.idx, int'(phase), e.ph);
            chk("busy",  e.idx, int'(busy),  (e.ph != P_IDLE) ? 1 : 0);
        end
    end

    // One clock of stimulus; the expectation describes the state after it.
    task automatic cyc(input bit se, input bit fl, input int lvl, input int ph);
        exp_t e;
        @(negedge clk);
        #1;
        step_en = se;
        flick   = fl;
        e.lvl = lvl;
        e.ph  = ph;
        e.idx = n_pushed++;
        sb.push_back(e);
    endtask

    // Walk the level from 'from' to 'to' one step at a time; the phase
    // reads ph_end once 'to' is reached.
    task automatic ramp(input int from, input int to, input int ph,
                        input int ph_end, input bit fl);
        int l;
        int d;
        d = (to >= from) ? 1 : -1;
        l = from;
        forever begin
            cyc(1'b1, fl, l, (l == to) ? ph_end : ph);
            if (l == to) break;
            l += d;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached with %0d pending", sb.size());
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0;
        step_en = 1'b0;
        flick   = 1'b0;
        #2;
        chk("rst_lamps", 0, int'(lamps), 0);
        chk("rst_phase", 0, int'(phase), P_IDLE);
        chk("rst_busy",  0, int'(busy),  0);
        @(negedge clk);
        #1;
        reset_n = 1'b1;

        // IDLE holds without flick.
        repeat (20) cyc(1'b1, 1'b0, 0, P_IDLE);

        // Full pattern, single flick pulse.
        cyc(1'b1, 1'b1, 1, P_UP1);
        ramp(2, 6, P_UP1, P_DN1, 1'b0);
        ramp(5, 0, P_DN1, P_UP2, 1'b0);
        ramp(1, 11, P_UP2, P_DN2, 1'b0);
        ramp(10, 5, P_DN2, P_UP3, 1'b0);
        ramp(6, 16, P_UP3, P_DN3, 1'b0);
        ramp(15, 0, P_DN3, P_IDLE, 1'b0);
        repeat (3) cyc(1'b1, 1'b0, 0, P_IDLE);

        // Kickback in UP2 at 6.
        cyc(1'b1, 1'b1, 1, P_UP1);
        ramp(2, 6, P_UP1, P_DN1, 1'b0);
        ramp(5, 0, P_DN1, P_UP2, 1'b0);
        ramp(1, 5, P_UP2, P_UP2, 1'b0);
        cyc(1'b1, 1'b1, 6, P_DN1);
        ramp(5, 0, P_DN1, P_UP2, 1'b0);
        ramp(1, 11, P_UP2, P_DN2, 1'b0);
        ramp(10, 7, P_DN2, P_DN2, 1'b0);
        // Frozen mid-DN2; flick toggling must be ignored too.
        for (int i = 0; i < 10; i++) cyc(1'b0, i[0], 7, P_DN2);
        ramp(6, 5, P_DN2, P_UP3, 1'b0);
        // Kickback in UP3 at 11.
        ramp(6, 10, P_UP3, P_UP3, 1'b0);
        cyc(1'b1, 1'b1, 11, P_DN2);
        ramp(10, 5, P_DN2, P_UP3, 1'b0);
        // Kickback in UP3 at 6: one down step to 5, then UP3 again.
        cyc(1'b1, 1'b1, 6, P_DN2);
        cyc(1'b1, 1'b0, 5, P_UP3);
        ramp(6, 16, P_UP3, P_DN3, 1'b0);
        ramp(15, 1, P_DN3, P_DN3, 1'b0);
        // flick on the DN3 step reaching 0 is ignored; one IDLE step follows.
        cyc(1'b1, 1'b1, 0, P_IDLE);

        // flick held high: UP1 ignores it, UP2 loops on kickback at 6.
        cyc(1'b1, 1'b1, 1, P_UP1);
        ramp(2, 6, P_UP1, P_DN1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            ramp(5, 0, P_DN1, P_UP2, 1'b1);
            ramp(1, 6, P_UP2, P_DN1, 1'b1);
        end
        ramp(5, 0, P_DN1, P_UP2, 1'b1);

        // Async reset at level 9 in UP2.
        ramp(1, 5, P_UP2, P_UP2, 1'b0);
        ramp(6, 9, P_UP2, P_UP2, 1'b0);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_lamps", 1, int'(lamps), 0);
        chk("arst_phase", 1, int'(phase), P_IDLE);
        chk("arst_busy",  1, int'(busy),  0);
        @(negedge clk);
        #1;
        reset_n = 1'b1;
        cyc(1'b1, 1'b0, 0, P_IDLE);
        cyc(1'b0, 1'b1, 0, P_IDLE);
        cyc(1'b1, 1'b1, 1, P_UP1);
        cyc(1'b1, 1'b0, 2, P_UP1);

        repeat (3) @(negedge clk);
        chk("sb_drained", 2, sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bound_flasher_ctrl.md
# bound_flasher_ctrl

Sequencing controller for the 16-lamp bound flasher. It owns a 5-bit lamp level held in an up/down counter and drives the counter's direction and enable through a six-phase on/off pattern started by `flick`. `flick` also triggers kickback at the 6- and 11-lamp boundaries. It sits between the user input and the lamp outputs, and it is the only block that commands the level counter.

## Interface
- `N_LAMPS`, 16, number of lamps; the level register is `$clog2(N_LAMPS+1)` bits wide.
- `B_LO`, 6, first boundary level (lamps 0..5 lit).
- `B_HI`, 11, second boundary level (lamps 0..10 lit); requires 0 < `B_LO` < `B_HI` < `N_LAMPS`.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `flick`  in  1  start / kickback request; level-sampled, no edge detection.
- `step_en`  in  1  step strobe from the prescaler; the level moves at most one step per cycle with `step_en`=1.
- `lamps`  out  `N_LAMPS`  thermometer output; `lamps[i]` = 1 iff i < level.
- `busy`  out  1  high in every phase except IDLE.
- `phase`  out  3  current phase code, for debug and verification.

## Operation
Phases (encoding in the package), as direction, target level, next phase:
- IDLE=0: level 0.
- UP1=1: up to `B_LO`, then DN1.
- DN1=2: down to 0, then UP2.
- UP2=3: up to `B_HI`, then DN2.
- DN2=4: down to `B_LO`−1, then UP3.
- UP3=5: up to `N_LAMPS`, then DN3.
- DN3=6: down to 0, then IDLE.

Rules:
- All actions happen only on cycles with `step_en`=1. With `step_en`=0, level and phase hold and `flick` is ignored.
- In IDLE, `step_en` & `flick` sets level to 1 and phase to UP1 in the same step. `flick`=0 keeps IDLE.
- In the other phases, each step does level ± 1. When the new level equals the phase target, the phase becomes the next phase, effective for the following step.
- Kickback in UP2: if the new level is `B_LO` or `B_HI` and `flick`=1 on that step, the next phase is DN1 instead of continuing or advancing.
- Kickback in UP3: if the new level is `B_LO` or `B_HI` and `flick`=1, the next phase is DN2.
- `flick` is never examined in UP1, DN1, DN2 or DN3.
- A kickback into DN2 at level `B_LO` still needs one down step to reach `B_LO`−1. After that, the normal transition to UP3 applies.
- On DN3 reaching 0 the block returns to IDLE. If `flick` is high on a later step in IDLE, it restarts at UP1. At least one step is always spent in IDLE.
- The level never leaves [0, `N_LAMPS`]; an out-of-range value is a design error.

## Timing
- Reset: phase IDLE, level 0, `lamps`=0, `busy`=0, `phase`=0. This takes effect immediately on `reset_n` falling, mid-sequence included.
- After `reset_n` rises, the first rising `clk` edge evaluates normally.
- `lamps`, `busy` and `phase` are derived from registers only. There is no combinational path from `flick` or `step_en` to any output.
- Latency: `lamps` changes exactly one `clk` edge after the `step_en` cycle that causes the step.
- Full pattern with no kickback: 6+6+11+6+11+16 = 56 steps from the IDLE-exit step to the return to IDLE.

## Structure
- Package `bf_pkg`:
  - phase enum, 3 bits;
  - default `N_LAMPS`, `B_LO`, `B_HI` constants;
  - level width function.
- Sub-module `bf_level_counter`:
  - parameterised-width up/down counter with `clk`, `reset_n`, `load`, `load_val`, `upcount`, `enable`, `out`;
  - the controller drives `upcount`, `enable` and `load` (for the IDLE→UP1 set-to-1).
- The FSM plus thermometer decode stay in `bound_flasher_ctrl`.

## Test plan
- Reset then `step_en`=1 every cycle, `flick`=0 → IDLE held, `lamps`=0 for 20 cycles.
- One-step `flick` pulse in IDLE, then `flick`=0 → level sequence 1..6, 5..0, 1..11, 10..5, 6..16, 15..0, then IDLE. That is 56 steps, with `lamps` transitions of 0x0001 through 0x003F, 0x07FF and 0xFFFF.
- `flick`=1 on the UP2 step reaching level 6 → next steps 5,4,…,0 (DN1), then UP2 restarts from 1.
- `flick`=1 on the UP3 step reaching level 11 → next steps 10..5 (DN2), then UP3 climbs again to 16.
- `flick` held high for the whole sequence → UP1 ignores it. UP2 kicks back at 6, re-enters UP2 and kicks back at 6 each time. This is a stable loop, `busy` stays 1.
- Interruptions:
  - `reset_n` pulsed low asynchronously at level 9 in UP2 → `lamps`=0 and IDLE within the same cycle.
  - `step_en`=0 for 10 cycles mid-DN2 → level frozen throughout.
